fpu_wb_arb: RTL and testbench
=============================

# fpu_wb_arb

Writeback collector for the FPU: captures results from the single-cycle `fmul` datapath and from a second FPU result source (fadd/fdiv/conversion path) into per-source FIFOs. It arbitrates them round-robin onto the single FP register-file write port. It also accumulates a sticky overflow flag. It sits directly downstream of `fmul` and upstream of the FP register file.

## Interface
Parameters:
- `DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `TAG_W`, 5: destination register index width.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `rstn`, in, 1: reset. Asynchronous, active-low.
- `mul_valid`, in, 1: `fmul` result valid.
- `mul_ready`, out, 1: mul FIFO not full.
- `mul_tag`, in, TAG_W: destination register of the mul result.
- `mul_data`, in, 32: `fmul` `y`.
- `mul_ovf`, in, 1: `fmul` `ovf`.
- `aux_valid` / `aux_ready` / `aux_tag` / `aux_data` / `aux_ovf`: same meaning, second source.
- `wb_stall`, in, 1: register-file port unavailable this cycle.
- `wb_we`, out, 1: write enable.
- `wb_addr`, out, TAG_W: write address.
- `wb_data`, out, 32: write data.
- `ovf_sticky`, out, 1: an overflowed result has been written back since the last clear.
- `ovf_clr`, in, 1: clear `ovf_sticky`.
- `pending`, out, 1: a result is held in a FIFO or in the output register.

## Operation
- Push: `X_valid && X_ready` at a rising edge stores {tag, data, ovf} into source X's FIFO.
  - `X_ready = !full`, combinational from FIFO state only, never from `X_valid`.
  - No push when full. Valid held while not ready keeps its payload stable. Upstream is responsible for this; the block does not check it.
- FIFO order is preserved within a source. There is no ordering guarantee across sources.
- Arbitration is evaluated each cycle when `wb_stall == 0`:
  - If exactly one FIFO is non-empty, grant it.
  - If both are non-empty, grant the side named by `rr_ptr`, then toggle `rr_ptr`.
  - `rr_ptr` changes only on a contended grant. Its reset value is mul.
- Grant pops the head of that FIFO. On the next edge it loads `wb_we=1`, `wb_addr=tag`, `wb_data=data`.
- Cycles without a grant (empty or `wb_stall=1`) load `wb_we=0`. `wb_addr`/`wb_data` hold their previous values.
- Simultaneous push and pop on the same FIFO (not full): both occur and the count is unchanged. Push into an empty FIFO is not bypassed; it pops next cycle at the earliest.
- `ovf_sticky` is set on the edge where `wb_we` loads 1 with the entry's ovf bit = 1. It is cleared by `ovf_clr`. If set and clear occur in the same cycle, set wins.
- `pending = !mul_empty || !aux_empty || wb_we`.
- No data modification: payloads pass through bit-exact, including zero/denormal-flushed values from `fmul`.

## Timing
- Reset (async assert, sync-safe release) produces:
  - FIFOs empty, `rr_ptr=mul`.
  - `wb_we=0`, `wb_addr=0`, `wb_data=0`, `ovf_sticky=0`, `pending=0`.
  - `mul_ready=aux_ready=1` in the first cycle after deassertion.
- Latency: an uncontended result accepted at edge E0 appears with `wb_we=1` after edge E1, a 2-edge latency.
- Throughput: one writeback per cycle aggregate. Under continuous contention each source gets every other slot.
- `wb_stall` is sampled combinationally in the grant cycle. A stalled cycle neither pops nor toggles `rr_ptr`.
- Reset mid-operation discards all queued results. Upstream must also be reset.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full/empty is resolved by an extra count bit (count width log2(DEPTH)+1).

## Structure
- Shared package `fpu_pkg`:
  - `fp_word_t` (32 bits).
  - The `wb_entry_t` struct {tag, data, ovf}.
  - `localparam SRC_MUL=0, SRC_AUX=1`.
- Sub-module `fpu_res_fifo`: synchronous DEPTH-entry FIFO of `wb_entry_t` with push/pop/full/empty. It is instantiated twice.
- The top level holds the arbiter, `rr_ptr`, the output register, and the sticky flag.

## Test plan
- Reset then a single mul push {tag=3, data=0x40800000, ovf=0} at E0: `wb_we=1`, `wb_addr=3`, `wb_data=0x40800000` after E1; `pending` falls after E2.
- Both sources push every cycle (mul tags 1,2,3…, aux tags 17,18,19…): writebacks alternate 1,17,2,18,…; `aux_ready` drops when its FIFO fills at DEPTH=4 and no entry is lost.
- `wb_stall=1` for 6 cycles while pushing 4 mul results: `mul_ready=0` after the 4th push, `wb_we` stays 0; after release, 4 writebacks in order on 4 consecutive cycles.
- Mul push with ovf=1 written back in the same cycle `ovf_clr=1`: `ovf_sticky=1`; a later `ovf_clr` alone gives `ovf_sticky=0`.
- Full FIFO plus simultaneous pop and attempted push: `ready=0`, so there is no push; next cycle `ready=1`, then push and pop occur together with the count held at 3.
- `rstn` asserted asynchronously mid-burst with 3 entries queued: outputs are zero immediately, no further `wb_we`, and `ready=1` after release.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU writeback types: the 32-bit result word, the queued writeback entry,
// and the source indices used by the writeback arbiter.
package fpu_pkg;

   localparam int FP_TAG_W = 5;

   typedef logic [31:0] fp_word_t;

   typedef struct packed {
      logic [FP_TAG_W-1:0] tag;
      fp_word_t            data;
      logic                ovf;
   } wb_entry_t;

   localparam logic SRC_MUL = 1'b0;
   localparam logic SRC_AUX = 1'b1;

endpackage

// File: rtl/fpu_wb_arb_if.sv
// Bus bundle between the two FPU result producers, the writeback collector and
// the FP register-file write port.
interface fpu_wb_arb_if
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5
);

   logic             mul_valid;
   logic             mul_ready;
   logic [TAG_W-1:0] mul_tag;
   fp_word_t         mul_data;
   logic             mul_ovf;

   logic             aux_valid;
   logic             aux_ready;
   logic [TAG_W-1:0] aux_tag;
   fp_word_t         aux_data;
   logic             aux_ovf;

   logic             wb_stall;
   logic             wb_we;
   logic [TAG_W-1:0] wb_addr;
   fp_word_t         wb_data;

   logic             ovf_sticky;
   logic             ovf_clr;
   logic             pending;

   modport master (
      output mul_valid, mul_tag, mul_data, mul_ovf,
      output aux_valid, aux_tag, aux_data, aux_ovf,
      output wb_stall, ovf_clr,
      input  mul_ready, aux_ready,
      input  wb_we, wb_addr, wb_data, ovf_sticky, pending
   );

   modport slave (
      input  mul_valid, mul_tag, mul_data, mul_ovf,
      input  aux_valid, aux_tag, aux_data, aux_ovf,
      input  wb_stall, ovf_clr,
      output mul_ready, aux_ready,
      output wb_we, wb_addr, wb_data, ovf_sticky, pending
   );

endinterface

// File: rtl/fpu_res_fifo.sv
// Per-source result FIFO; pushes are refused when full and pops when empty.
// Full/empty come from a count one bit wider than the wrapping pointers.
module fpu_res_fifo
   import fpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = wb_entry_t
) (
   input  logic   clk,
   input  logic   rstn,
   input  logic   i_push,
   input  entry_t i_entry,
   input  logic   i_pop,
   output entry_t o_head,
   output logic   o_full,
   output logic   o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = 1;
   localparam logic [PTR_W:0]   CNT_ONE = 1;

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   // DEPTH is a power of two, so the count MSB alone marks full.
   assign o_full  = r_count[PTR_W];
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_entry;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
         else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      end
   end

endmodule

// File: rtl/fpu_wb_arb.sv
// FPU writeback collector: queues fmul and aux results, round-robins them onto the
// single FP register-file write port, and keeps a sticky overflow flag.
module fpu_wb_arb
   import fpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 5
) (
   input logic         clk,
   input logic         rstn,
   fpu_wb_arb_if.slave bus
);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      fp_word_t         data;
      logic             ovf;
   } entry_t;

   entry_t           w_mul_in;
   entry_t           w_aux_in;
   entry_t           w_mul_head;
   entry_t           w_aux_head;
   entry_t           w_win;
   logic             w_mul_full;
   logic             w_mul_empty;
   logic             w_aux_full;
   logic             w_aux_empty;
   logic             w_contend;
   logic             w_grant_mul;
   logic             w_grant_aux;
   logic             w_grant;

   logic             r_rr_ptr;
   logic             r_wb_we;
   logic [TAG_W-1:0] r_wb_addr;
   fp_word_t         r_wb_data;
   logic             r_ovf_sticky;

   assign w_mul_in = '{tag: bus.mul_tag, data: bus.mul_data, ovf: bus.mul_ovf};
   assign w_aux_in = '{tag: bus.aux_tag, data: bus.aux_data, ovf: bus.aux_ovf};

   fpu_res_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_mul_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (bus.mul_valid),
      .i_entry (w_mul_in),
      .i_pop   (w_grant_mul),
      .o_head  (w_mul_head),
      .o_full  (w_mul_full),
      .o_empty (w_mul_empty)
   );

   fpu_res_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_aux_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .i_push  (bus.aux_valid),
      .i_entry (w_aux_in),
      .i_pop   (w_grant_aux),
      .o_head  (w_aux_head),
      .o_full  (w_aux_full),
      .o_empty (w_aux_empty)
   );

   // rr_ptr only arbitrates when both queues hold work; a lone source always wins.
   assign w_contend   = !w_mul_empty && !w_aux_empty;
   assign w_grant_mul = !bus.wb_stall && !w_mul_empty && (w_aux_empty || r_rr_ptr == SRC_MUL);
   assign w_grant_aux = !bus.wb_stall && !w_aux_empty && (w_mul_empty || r_rr_ptr == SRC_AUX);
   assign w_grant     = w_grant_mul || w_grant_aux;
   assign w_win       = w_grant_aux ? w_aux_head : w_mul_head;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rr_ptr     <= SRC_MUL;
         r_wb_we      <= 1'b0;
         r_wb_addr    <= '0;
         r_wb_data    <= '0;
         r_ovf_sticky <= 1'b0;
      end else begin
         r_wb_we <= w_grant;
         if (w_grant) begin
            r_wb_addr <= w_win.tag;
            r_wb_data <= w_win.data;
         end
         if (!bus.wb_stall && w_contend) r_rr_ptr <= ~r_rr_ptr;
         if (w_grant && w_win.ovf) r_ovf_sticky <= 1'b1;
         else if (bus.ovf_clr)     r_ovf_sticky <= 1'b0;
      end
   end

   assign bus.mul_ready  = !w_mul_full;
   assign bus.aux_ready  = !w_aux_full;
   assign bus.wb_we      = r_wb_we;
   assign bus.wb_addr    = r_wb_addr;
   assign bus.wb_data    = r_wb_data;
   assign bus.ovf_sticky = r_ovf_sticky;
   assign bus.pending    = !w_mul_empty || !w_aux_empty || r_wb_we;

endmodule

// File: tb/tb_fpu_wb_arb.sv
// Bench for fpu_wb_arb: directed scenarios plus a random phase, all checked
// against a queue-based reference of the writeback rules.
module tb_fpu_wb_arb;
   import fpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int TAG_W = 5;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fpu_wb_arb_if #(.TAG_W(TAG_W)) bus ();

   fpu_wb_arb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
      logic             ovf;
   } ent_t;

   ent_t        mq[$];
   ent_t        aq[$];
   bit          m_rr;
   logic        m_we;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_sticky;

   int n_checks = 0;
   int n_errors = 0;
   bit last_mul_acc, last_aux_acc;
   int mt, at, wr_cnt;
   bit saw_aux_full;
   int wbq[$];
   int exp_seq[5];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      aq.delete();
      m_rr     = 1'b0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_data   = '0;
      m_sticky = 1'b0;
   endtask

   // One clock: check readiness, apply the edge, update the reference, check outputs.
   task automatic step();
      ent_t e, min, ain;
      bit mne, ane, gm, ga, pm, pa, clr, stall;
      chk("mul_ready", bus.mul_ready, 32'(mq.size() < DEPTH));
      chk("aux_ready", bus.aux_ready, 32'(aq.size() < DEPTH));
      mne   = mq.size() != 0;
      ane   = aq.size() != 0;
      stall = bus.wb_stall;
      clr   = bus.ovf_clr;
      pm    = bus.mul_valid && (mq.size() < DEPTH);
      pa    = bus.aux_valid && (aq.size() < DEPTH);
      min   = '{bus.mul_tag, bus.mul_data, bus.mul_ovf};
      ain   = '{bus.aux_tag, bus.aux_data, bus.aux_ovf};
      gm = 1'b0;
      ga = 1'b0;
      if (!stall) begin
         if (mne && ane) begin
            gm   = !m_rr;
            ga   = m_rr;
            m_rr = !m_rr;
         end else begin
            gm = mne;
            ga = ane;
         end
      end
      @(posedge clk);
      e = '{default: '0};
      if (gm)      e = mq.pop_front();
      else if (ga) e = aq.pop_front();
      if (gm || ga) begin
         m_we   = 1'b1;
         m_addr = e.tag;
         m_data = e.data;
      end else begin
         m_we = 1'b0;
      end
      if ((gm || ga) && e.ovf) m_sticky = 1'b1;
      else if (clr)            m_sticky = 1'b0;
      if (pm) mq.push_back(min);
      if (pa) aq.push_back(ain);
      #1;
      chk("wb_we", bus.wb_we, 32'(m_we));
      chk("wb_addr", bus.wb_addr, 32'(m_addr));
      chk("wb_data", bus.wb_data, m_data);
      chk("ovf_sticky", bus.ovf_sticky, 32'(m_sticky));
      chk("pending", bus.pending, 32'(mq.size() != 0 || aq.size() != 0 || m_we));
      last_mul_acc = pm;
      last_aux_acc = pa;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.mul_valid = 0; bus.mul_tag = '0; bus.mul_data = '0; bus.mul_ovf = 0;
      bus.aux_valid = 0; bus.aux_tag = '0; bus.aux_data = '0; bus.aux_ovf = 0;
      bus.wb_stall  = 0; bus.ovf_clr = 0;
      model_reset();

      // Reset state
      #12;
      chk("rst_we", bus.wb_we, 0);
      chk("rst_addr", bus.wb_addr, 0);
      chk("rst_data", bus.wb_data, 0);
      chk("rst_sticky", bus.ovf_sticky, 0);
      chk("rst_pending", bus.pending, 0);
      @(posedge clk);
      #1 rstn = 1'b1;

      // Single uncontended mul result: visible after E1, pending gone after E2
      bus.mul_valid = 1; bus.mul_tag = 5'd3; bus.mul_data = 32'h4080_0000; bus.mul_ovf = 0;
      step();
      chk("t1_we_e0", bus.wb_we, 0);
      bus.mul_valid = 0;
      step();
      chk("t1_we_e1", bus.wb_we, 1);
      chk("t1_addr", bus.wb_addr, 3);
      chk("t1_data", bus.wb_data, 32'h4080_0000);
      step();
      chk("t1_pending_e2", bus.pending, 0);

      // Both sources push every cycle; payload held while not accepted
      mt = 1; at = 17; wr_cnt = 0; saw_aux_full = 0;
      wbq.delete();
      for (int i = 0; i < 16; i++) begin
         bus.mul_valid = 1; bus.mul_tag = 5'(mt); bus.mul_data = 32'h3f80_0000 + 32'(mt);
         bus.aux_valid = 1; bus.aux_tag = 5'(at); bus.aux_data = 32'h0000_0100 + 32'(at);
         if (!bus.aux_ready) saw_aux_full = 1;
         step();
         if (last_mul_acc) mt++;
         if (last_aux_acc) at++;
         if (bus.wb_we) begin wbq.push_back(int'(bus.wb_addr)); wr_cnt++; end
      end
      bus.mul_valid = 0; bus.aux_valid = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.wb_we) begin wbq.push_back(int'(bus.wb_addr)); wr_cnt++; end
      end
      chk("t2_aux_full_seen", 32'(saw_aux_full), 1);
      chk("t2_wb0", 32'(wbq[0]), 1);
      chk("t2_wb1", 32'(wbq[1]), 17);
      chk("t2_wb2", 32'(wbq[2]), 2);
      chk("t2_wb3", 32'(wbq[3]), 18);
      chk("t2_no_loss", 32'(wr_cnt), 32'((mt - 1) + (at - 17)));

      // Stall for 6 cycles while filling the mul FIFO
      bus.wb_stall = 1;
      for (int i = 0; i < 4; i++) begin
         bus.mul_valid = 1; bus.mul_tag = 5'(8 + i); bus.mul_data = 32'hc000_0000 + 32'(i);
         step();
         chk("t3_we_stalled", bus.wb_we, 0);
      end
      bus.mul_valid = 0;
      chk("t3_mul_full", bus.mul_ready, 0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t3_we_stalled", bus.wb_we, 0);
      end
      // Release with a push attempted against the full FIFO
      exp_seq = '{8, 9, 10, 11, 20};
      bus.wb_stall = 0;
      bus.mul_valid = 1; bus.mul_tag = 5'd20; bus.mul_data = 32'h0000_0001;
      chk("t5_ready_full", bus.mul_ready, 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) chk("t5_ready_after_pop", bus.mul_ready, 1);
         step();
         if (last_mul_acc) bus.mul_valid = 0;
         chk("t3_seq_we", bus.wb_we, 1);
         chk("t3_seq_addr", bus.wb_addr, 32'(exp_seq[i]));
      end
      step();

      // Overflow written back in the same cycle as a clear: set wins
      bus.mul_valid = 1; bus.mul_tag = 5'd5; bus.mul_data = 32'h7f80_0000; bus.mul_ovf = 1;
      step();
      bus.mul_valid = 0; bus.mul_ovf = 0; bus.ovf_clr = 1;
      step();
      chk("t4_sticky_set", bus.ovf_sticky, 1);
      bus.ovf_clr = 0;
      step();
      chk("t4_sticky_hold", bus.ovf_sticky, 1);
      bus.ovf_clr = 1;
      step();
      chk("t4_sticky_clr", bus.ovf_sticky, 0);
      bus.ovf_clr = 0;

      // Random traffic, stalls and clears
      for (int i = 0; i < 400; i++) begin
         if (!(bus.mul_valid && !last_mul_acc)) begin
            bus.mul_valid = 1'($urandom_range(0, 1));
            bus.mul_tag   = 5'($urandom);
            bus.mul_data  = $urandom;
            bus.mul_ovf   = ($urandom_range(0, 3) == 0);
         end
         if (!(bus.aux_valid && !last_aux_acc)) begin
            bus.aux_valid = 1'($urandom_range(0, 1));
            bus.aux_tag   = 5'($urandom);
            bus.aux_data  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            bus.aux_ovf   = ($urandom_range(0, 3) == 0);
         end
         bus.wb_stall = ($urandom_range(0, 3) == 0);
         bus.ovf_clr  = ($urandom_range(0, 7) == 0);
         step();
      end
      bus.mul_valid = 0; bus.aux_valid = 0; bus.wb_stall = 0; bus.ovf_clr = 0;
      for (int i = 0; i < 10; i++) step();

      // Async reset mid-burst with results queued and a writeback in flight
      bus.mul_valid = 1; bus.mul_tag = 5'd7; bus.mul_data = 32'h1234_5678; bus.mul_ovf = 1;
      bus.aux_valid = 1; bus.aux_tag = 5'd22; bus.aux_data = 32'h8765_4321;
      step();
      bus.mul_tag = 5'd8; bus.mul_ovf = 0; bus.aux_tag = 5'd23;
      step();
      bus.mul_tag = 5'd9; bus.aux_valid = 0;
      step();
      bus.mul_valid = 0;
      chk("t6_pre_we", bus.wb_we, 1);
      #2 rstn = 1'b0;
      #1;
      chk("t6_rst_we", bus.wb_we, 0);
      chk("t6_rst_addr", bus.wb_addr, 0);
      chk("t6_rst_data", bus.wb_data, 0);
      chk("t6_rst_sticky", bus.ovf_sticky, 0);
      chk("t6_rst_pending", bus.pending, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rstn = 1'b1;
      chk("t6_mul_ready", bus.mul_ready, 1);
      chk("t6_aux_ready", bus.aux_ready, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_we", bus.wb_we, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
